rr_sel_arbiter: RTL

//   Four-way round-robin arbiter that produces a registered 2-bit channel index

---
 rtl/rr_sel_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/rr_sel_arbiter.sv
// rtl/rr_sel_arbiter.sv - four-way round-robin arbiter with bounded tenure and break-before-make gap
module rr_sel_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arb_en,
    input  logic [3:0] req,
    input  logic       owner_release,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic       timeout,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       last;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       pick;
    logic             found;
    logic [1:0]       idx;
    logic             hold_limit;
    logic             tenure_end;

    // Scan last+1 .. last+4 (mod 4); the final step revisits last itself.
    always_comb begin
        found = 1'b0;
        pick  = last;
        idx   = last;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign hold_limit = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign tenure_end = owner_release || !req[sel] || hold_limit || !arb_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel       <= 2'b00;
            sel_valid <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            last      <= 2'b11;
            hold_cnt  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_en && found) begin
                        state     <= ST_GRANT;
                        sel       <= pick;
                        sel_valid <= 1'b1;
                        last      <= pick;
                        hold_cnt  <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!arb_en) begin
                        state     <= ST_IDLE;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (tenure_end) begin
                        // Release beats the hold limit when both land on the same cycle.
                        state     <= ST_GAP;
                        sel_valid <= 1'b0;
                        timeout   <= hold_limit && !owner_release && req[sel];
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
